// File: rtl/latq_bank_wr_ctrl.sv
// Write sequencer for a latq latch bank: accept -> D setup -> one-word E pulse -> D hold -> done.
// Latency: E rises SETUP_CYC edges after accept; READY/DONE return SETUP+PULSE+HOLD edges after accept.
// Backpressure: WR_READY is high only in IDLE; address and data are ignored while it is low.
module latq_bank_wr_ctrl #(
  parameter int WIDTH     = 8,
  parameter int NWORDS    = 4,
  parameter int AW        = 2,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 1,
  parameter int HOLD_CYC  = 1
) (
  input  logic              CLK,
  input  logic              RN,
  input  logic              WR_VALID,
  output logic              WR_READY,
  input  logic [AW-1:0]     WR_ADDR,
  input  logic [WIDTH-1:0]  WR_DATA,
  output logic [WIDTH-1:0]  LAT_D,
  output logic [NWORDS-1:0] LAT_E,
  output logic              WR_DONE,
  output logic              WR_ERR
);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

  localparam logic [AW:0]       NW_LIM   = (AW+1)'(NWORDS);
  localparam logic [3:0]        SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0]        PULSE_LD = 4'(PULSE_CYC - 1);
  localparam logic [3:0]        HOLD_LD  = 4'(HOLD_CYC - 1);
  localparam logic [NWORDS-1:0] ONE_HOT0 = NWORDS'(1);

  state_t        state;
  logic [3:0]    cnt;
  logic [AW-1:0] addr;
  logic          in_range;

  assign in_range = ({1'b0, addr} < NW_LIM);

  // Every output is a flop; reset drops the enables without waiting for a clock.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state    <= IDLE;
      cnt      <= '0;
      addr     <= '0;
      LAT_D    <= '0;
      LAT_E    <= '0;
      WR_READY <= 1'b1;
      WR_DONE  <= 1'b0;
      WR_ERR   <= 1'b0;
    end else begin
      WR_DONE <= 1'b0;
      WR_ERR  <= 1'b0;
      case (state)
        IDLE: begin
          if (WR_VALID) begin
            addr     <= WR_ADDR;
            LAT_D    <= WR_DATA;
            cnt      <= SETUP_LD;
            WR_READY <= 1'b0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == 4'd0) begin
            LAT_E <= in_range ? (ONE_HOT0 << addr) : '0;
            cnt   <= PULSE_LD;
            state <= PULSE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        PULSE: begin
          if (cnt == 4'd0) begin
            LAT_E <= '0;
            cnt   <= HOLD_LD;
            state <= HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          if (cnt == 4'd0) begin
            WR_READY <= 1'b1;
            WR_DONE  <= 1'b1;
            WR_ERR   <= ~in_range;
            state    <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_latq_bank_wr_ctrl.sv
// Bench for latq_bank_wr_ctrl: default, wide-margin and 3-word instances driven from one clock.
module tb_latq_bank_wr_ctrl;

  logic clk = 1'b0;
  logic rn;
  always #5 clk = ~clk;

  logic       vld_a, rdy_a, done_a, err_a;
  logic [1:0] addr_a;
  logic [7:0] dat_a, d_a;
  logic [3:0] e_a;

  logic       vld_b, rdy_b, done_b, err_b;
  logic [1:0] addr_b;
  logic [7:0] dat_b, d_b;
  logic [3:0] e_b;

  logic       vld_c, rdy_c, done_c, err_c;
  logic [1:0] addr_c;
  logic [7:0] dat_c, d_c;
  logic [2:0] e_c;

  latq_bank_wr_ctrl u_a (
    .CLK(clk), .RN(rn), .WR_VALID(vld_a), .WR_READY(rdy_a), .WR_ADDR(addr_a), .WR_DATA(dat_a),
    .LAT_D(d_a), .LAT_E(e_a), .WR_DONE(done_a), .WR_ERR(err_a));

  latq_bank_wr_ctrl #(.SETUP_CYC(3), .PULSE_CYC(2), .HOLD_CYC(2)) u_b (
    .CLK(clk), .RN(rn), .WR_VALID(vld_b), .WR_READY(rdy_b), .WR_ADDR(addr_b), .WR_DATA(dat_b),
    .LAT_D(d_b), .LAT_E(e_b), .WR_DONE(done_b), .WR_ERR(err_b));

  latq_bank_wr_ctrl #(.NWORDS(3)) u_c (
    .CLK(clk), .RN(rn), .WR_VALID(vld_c), .WR_READY(rdy_c), .WR_ADDR(addr_c), .WR_DATA(dat_c),
    .LAT_D(d_c), .LAT_E(e_c), .WR_DONE(done_c), .WR_ERR(err_c));

  typedef struct packed {
    logic [1:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        sb[$];
  int         acc_hist[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  bit         mon_en = 1'b0;
  logic [7:0] bank[4];
  logic [7:0] ref_mem[4];

  logic [7:0] prev_d;
  logic [3:0] prev_e;
  int         d_age, e_cnt, hold_left;
  logic       dch;
  wr_t        exp_w;

  // Accepts on instance a feed the scoreboard and the reference memory.
  always @(posedge clk) begin
    cyc++;
    if (rn && vld_a && rdy_a) begin
      sb.push_back({addr_a, dat_a});
      acc_hist.push_back(cyc);
      ref_mem[addr_a] = dat_a;
    end
  end

  // Behavioural latq bank on instance a with setup/hold/width/one-hot checking.
  always @(negedge clk) begin
    if (!rn || !mon_en) begin
      prev_d = d_a; prev_e = '0; d_age = 0; e_cnt = 0; hold_left = 0;
    end else begin
      dch = (d_a !== prev_d);
      checks++;
      if ($countones(e_a) > 1) begin
        failures++; $display("FAIL onehot lat_e=%b required at most one bit", e_a);
      end
      checks++;
      if (dch && (e_a != 0 || prev_e != 0 || hold_left > 0)) begin
        failures++; $display("FAIL d_stable lat_d changed %h->%h with lat_e=%b hold_left=%0d", prev_d, d_a, e_a, hold_left);
      end
      if (hold_left > 0) hold_left--;
      d_age = dch ? 0 : d_age + 1;
      if (prev_e == 0 && e_a != 0) begin
        checks++;
        if (d_age < 1) begin failures++; $display("FAIL setup d_age=%0d required>=1", d_age); end
        e_cnt = 0;
      end
      if (e_a != 0) e_cnt++;
      if (prev_e != 0 && e_a == 0) begin
        checks++;
        if (e_cnt < 1) begin failures++; $display("FAIL width e_cnt=%0d required>=1", e_cnt); end
        hold_left = 1;
      end
      for (int w = 0; w < 4; w++) if (e_a[w]) bank[w] = d_a;
      prev_d = d_a; prev_e = e_a;
    end
    if (rn && done_a) begin
      checks++;
      if (sb.size() == 0) begin
        failures++; $display("FAIL sb_done unexpected wr_done with empty scoreboard");
      end else begin
        exp_w = sb.pop_front();
        if (err_a !== 1'b0 || d_a !== exp_w.data || bank[exp_w.addr] !== exp_w.data)
          begin
            failures++;
            $display("FAIL sb_write addr=%0d err=%b lat_d=%h bank=%h required err=0 data=%h",
                     exp_w.addr, err_a, d_a, bank[exp_w.addr], exp_w.data);
          end
      end
    end
  end

  task automatic drain();
    for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL drain pending=%0d required 0", sb.size()); end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rn = 1'b0; mon_en = 1'b0;
    vld_a = 0; addr_a = 0; dat_a = 0;
    vld_b = 0; addr_b = 0; dat_b = 0;
    vld_c = 0; addr_c = 0; dat_c = 0;
    @(negedge clk);
    checks++;
    if ({rdy_a, e_a, d_a, done_a, err_a} !== {1'b1, 4'b0, 8'h00, 1'b0, 1'b0}) begin
      failures++; $display("FAIL reset_state rdy=%b e=%b d=%h done=%b err=%b required 1/0000/00/0/0", rdy_a, e_a, d_a, done_a, err_a);
    end
    // First edge after reset release must accept.
    rn = 1'b1; vld_a = 1; addr_a = 2; dat_a = 8'hC3;
    @(negedge clk); vld_a = 0;
    @(negedge clk);
    checks++;
    if (e_a !== 4'b0100 || d_a !== 8'hC3) begin
      failures++; $display("FAIL first_accept e=%b d=%h required 0100/c3", e_a, d_a);
    end
    #2 rn = 1'b0;
    #1;
    checks++;
    if ({rdy_a, e_a, d_a, done_a, err_a} !== {1'b1, 4'b0, 8'h00, 1'b0, 1'b0}) begin
      failures++; $display("FAIL async_reset rdy=%b e=%b d=%h done=%b err=%b required 1/0000/00/0/0", rdy_a, e_a, d_a, done_a, err_a);
    end
    @(negedge clk); rn = 1'b1;
    sb.delete(); acc_hist.delete();
    for (int w = 0; w < 4; w++) begin bank[w] = 8'h00; ref_mem[w] = 8'h00; end
    mon_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    vld_a = 1; addr_a = 2; dat_a = 8'hA5;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (n == 0) vld_a = 0;
      checks++;
      if ({d_a, e_a, rdy_a, done_a, err_a} !== {8'hA5, (n == 1) ? 4'b0100 : 4'b0000, n >= 3, n == 3, 1'b0}) begin
        failures++;
        $display("FAIL single s%0d d=%h e=%b rdy=%b done=%b err=%b required a5/%b/%b/%b/0",
                 n, d_a, e_a, rdy_a, done_a, err_a, (n == 1) ? 4'b0100 : 4'b0000, n >= 3, n == 3);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] ad[3];
    logic [7:0] dt[3];
    int base, i;
    ad[0] = 2'd0; ad[1] = 2'd3; ad[2] = 2'd1;
    dt[0] = 8'h11; dt[1] = 8'h22; dt[2] = 8'h33;
    base = acc_hist.size(); i = 0;
    vld_a = 1; addr_a = ad[0]; dat_a = dt[0];
    for (int n = 0; n < 40 && i < 3; n++) begin
      @(negedge clk);
      if (acc_hist.size() > base + i) begin
        i++;
        if (i < 3) begin addr_a = ad[i]; dat_a = dt[i]; end
        else vld_a = 0;
      end
    end
    vld_a = 0;
    checks++;
    if (i != 3) begin
      failures++; $display("FAIL b2b_timeout accepts=%0d required 3", i);
    end else begin
      for (int k = 1; k < 3; k++) begin
        checks++;
        if (acc_hist[base+k] - acc_hist[base+k-1] != 4) begin
          failures++; $display("FAIL b2b_spacing gap=%0d required 4", acc_hist[base+k] - acc_hist[base+k-1]);
        end
      end
    end
  endtask

  task automatic test_margins();
    logic [3:0] ee;
    vld_b = 1; addr_b = 1; dat_b = 8'h3C;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (n == 0) vld_b = 0;
      ee = (n == 3 || n == 4) ? 4'b0010 : 4'b0000;
      checks++;
      if ({d_b, e_b, rdy_b, done_b, err_b} !== {8'h3C, ee, n >= 7, n == 7, 1'b0}) begin
        failures++;
        $display("FAIL margins s%0d d=%h e=%b rdy=%b done=%b err=%b required 3c/%b/%b/%b/0",
                 n, d_b, e_b, rdy_b, done_b, err_b, ee, n >= 7, n == 7);
      end
    end
  endtask

  task automatic test_out_of_range();
    vld_c = 1; addr_c = 3; dat_c = 8'h5A;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (n == 0) vld_c = 0;
      checks++;
      if ({d_c, e_c, rdy_c, done_c, err_c} !== {8'h5A, 3'b000, n >= 3, n == 3, n == 3}) begin
        failures++;
        $display("FAIL oor s%0d d=%h e=%b rdy=%b done=%b err=%b required 5a/000/%b/%b/%b",
                 n, d_c, e_c, rdy_c, done_c, err_c, n >= 3, n == 3, n == 3);
      end
    end
  endtask

  task automatic test_random();
    int target;
    target = acc_hist.size() + 1000;
    for (int n = 0; n < 20000 && acc_hist.size() < target; n++) begin
      @(negedge clk);
      vld_a  = ($urandom_range(0, 3) != 0);
      addr_a = 2'($urandom_range(0, 3));
      dat_a  = 8'($urandom);
    end
    vld_a = 0;
    checks++;
    if (acc_hist.size() < target) begin
      failures++; $display("FAIL random_timeout accepts=%0d required %0d", acc_hist.size(), target);
    end
    drain();
    for (int w = 0; w < 4; w++) begin
      checks++;
      if (bank[w] !== ref_mem[w]) begin
        failures++; $display("FAIL readback word%0d got=%h required %h", w, bank[w], ref_mem[w]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    drain();
    test_back_to_back();
    drain();
    test_margins();
    test_out_of_range();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
